// File: rtl/hbf_pkg.sv
// Shared types and default widths for the half-band filter sequencing slice.
// Imported by the coefficient bank, the controller and the bench.
package hbf_pkg;

    localparam int HBF_DATA_W   = 16;
    localparam int HBF_COEFF_W  = 16;
    localparam int HBF_NUM_TAPS = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        WAIT_OUT
    } hbf_ctrl_state_t;

    typedef logic [HBF_COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/hbf_coeff_bank.sv
// Coefficient register bank: guarded write port with error strobe and a flat read bus.
// Tap 0 sits in the least significant COEFF_W bits of o_coeff.
module hbf_coeff_bank
    import hbf_pkg::*;
#(
    parameter int COEFF_W  = HBF_COEFF_W,
    parameter int NUM_TAPS = HBF_NUM_TAPS,
    parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic                        i_wr_allow,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [COEFF_W-1:0]          i_wdata,
    output logic                        o_err,
    output logic [NUM_TAPS*COEFF_W-1:0] o_coeff
);

    logic [COEFF_W-1:0] r_bank [NUM_TAPS];
    logic               w_addr_ok;
    logic               w_wr;

    assign w_addr_ok = (int'(i_addr) < NUM_TAPS);
    assign w_wr      = i_we && i_wr_allow && w_addr_ok;
    // Any write that cannot land (wrong state or out-of-range index) is reported, not applied.
    assign o_err     = i_we && !(i_wr_allow && w_addr_ok);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_wr) begin
            r_bank[i_addr] <= i_wdata;
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
        assign o_coeff[k*COEFF_W +: COEFF_W] = r_bank[k];
    end

endmodule

// File: rtl/hbf_ctrl.sv
// Sequencing controller for the half-band decimator: coefficient bank, slot-gated
// sample feed, zero flush of the delay line and output-count based completion.
module hbf_ctrl
    import hbf_pkg::*;
#(
    parameter int DATA_W   = HBF_DATA_W,
    parameter int COEFF_W  = HBF_COEFF_W,
    parameter int NUM_TAPS = HBF_NUM_TAPS,
    parameter int FILT_DIV = 2,
    parameter int DECIM    = 2,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_TAPS)-1:0] cfg_addr,
    input  logic [COEFF_W-1:0]          cfg_wdata,
    input  logic                        start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        filt_valid,
    output logic [DATA_W-1:0]           filt_sample,
    output logic [NUM_TAPS*COEFF_W-1:0] filt_coeff,
    input  logic                        filt_out_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic                        cfg_err,
    output logic [CNT_W-1:0]            in_cnt,
    output logic [CNT_W-1:0]            out_cnt
);

    localparam int ADDR_W  = $clog2(NUM_TAPS);
    localparam int DIV_W   = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
    localparam int FLUSH_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS - 1) : 1;
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EXP_W   = CNT_W + ADDR_W;

    hbf_ctrl_state_t    r_state;
    hbf_ctrl_state_t    w_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic [WD_W-1:0]    r_wd_cnt;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_filt_valid;
    logic [DATA_W-1:0]  r_filt_sample;
    logic               r_done;
    logic               r_timeout;
    logic               r_cfg_err;

    logic               w_slot;
    logic               w_start_ok;
    logic               w_accept;
    logic               w_flush_push;
    logic               w_flush_last;
    logic               w_wd_expired;
    logic               w_out_met;
    logic [EXP_W-1:0]   w_exp;
    logic               w_bank_err;
    logic               w_s_ready;
    logic               w_busy;

    hbf_coeff_bank #(
        .COEFF_W  (COEFF_W),
        .NUM_TAPS (NUM_TAPS),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_we       (cfg_we),
        .i_wr_allow (r_state == IDLE),
        .i_addr     (cfg_addr),
        .i_wdata    (cfg_wdata),
        .o_err      (w_bank_err),
        .o_coeff    (filt_coeff)
    );

    // Widened so the tap-count offset cannot wrap the expected-output target.
    assign w_exp     = (EXP_W'(r_in_cnt) + EXP_W'(NUM_TAPS - 1)) / EXP_W'(DECIM);
    assign w_out_met = (EXP_W'(r_out_cnt) >= w_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (start) w_next = RUN;
            RUN:      if (w_accept && s_last) w_next = FLUSH;
            FLUSH:    if (w_flush_last) w_next = WAIT_OUT;
            WAIT_OUT: if (w_out_met || w_wd_expired) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_slot       = (r_div_cnt == DIV_W'(FILT_DIV - 1));
        w_start_ok   = start && (r_state == IDLE);
        w_s_ready    = (r_state == RUN) && w_slot;
        w_accept     = w_s_ready && s_valid;
        w_flush_push = (r_state == FLUSH) && w_slot;
        w_flush_last = w_flush_push && (r_flush_cnt == FLUSH_W'(NUM_TAPS - 2));
        w_wd_expired = (r_state == WAIT_OUT) && (r_wd_cnt == WD_W'(TIMEOUT - 1));
        w_busy       = (r_state != IDLE);
    end

    // Completion has priority over the watchdog when both fire on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_flush_cnt   <= '0;
            r_wd_cnt      <= '0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_filt_valid  <= 1'b0;
            r_filt_sample <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_filt_valid <= w_accept || w_flush_push;
            if (w_accept) begin
                r_filt_sample <= s_data;
            end else if (w_flush_push) begin
                r_filt_sample <= '0;
            end
            r_done <= (r_state == WAIT_OUT) && (w_out_met || w_wd_expired);

            if ((r_state == RUN) || (r_state == FLUSH)) begin
                r_div_cnt <= w_slot ? '0 : r_div_cnt + 1'b1;
            end else begin
                r_div_cnt <= '0;
            end

            if (w_accept && s_last) begin
                r_flush_cnt <= '0;
            end else if (w_flush_push) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end

            r_wd_cnt <= (r_state == WAIT_OUT) ? r_wd_cnt + 1'b1 : '0;

            if (w_start_ok) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (w_accept && (r_in_cnt != '1)) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
                if (filt_out_valid && w_busy && (r_out_cnt != '1)) begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
                if (w_wd_expired && !w_out_met) begin
                    r_timeout <= 1'b1;
                end
            end

            if (w_bank_err) begin
                r_cfg_err <= 1'b1;
            end else if (w_start_ok) begin
                r_cfg_err <= 1'b0;
            end
        end
    end

    assign s_ready     = w_s_ready;
    assign busy        = w_busy;
    assign filt_valid  = r_filt_valid;
    assign filt_sample = r_filt_sample;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cfg_err     = r_cfg_err;
    assign in_cnt      = r_in_cnt;
    assign out_cnt     = r_out_cnt;

endmodule

// File: tb/tb_hbf_ctrl.sv
// Randomised self-checking bench for hbf_ctrl; expected pushes, slot timing and
// completion cycle come from a cycle-count model of the controller's rules.
module tb_hbf_ctrl;
    import hbf_pkg::*;

    localparam int DATA_W   = 16;
    localparam int COEFF_W  = 16;
    localparam int NUM_TAPS = 11;
    localparam int FILT_DIV = 2;
    localparam int DECIM    = 2;
    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 256;
    localparam int ADDR_W   = $clog2(NUM_TAPS);
    localparam int BUS_W    = NUM_TAPS * COEFF_W;
    localparam int RUN_LIMIT = 4000;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [COEFF_W-1:0]  cfg_wdata;
    logic                start;
    logic                s_valid;
    logic                s_ready;
    logic [DATA_W-1:0]   s_data;
    logic                s_last;
    logic                filt_valid;
    logic [DATA_W-1:0]   filt_sample;
    logic [BUS_W-1:0]    filt_coeff;
    logic                filt_out_valid;
    logic                busy;
    logic                done;
    logic                timeout;
    logic                cfg_err;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    out_cnt;

    int     checkCount = 0;
    int     failCount  = 0;
    coeff_t modelCoeff [NUM_TAPS];

    hbf_ctrl #(
        .DATA_W   (DATA_W),
        .COEFF_W  (COEFF_W),
        .NUM_TAPS (NUM_TAPS),
        .FILT_DIV (FILT_DIV),
        .DECIM    (DECIM),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .start          (start),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .filt_valid     (filt_valid),
        .filt_sample    (filt_sample),
        .filt_coeff     (filt_coeff),
        .filt_out_valid (filt_out_valid),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cfg_err        (cfg_err),
        .in_cnt         (in_cnt),
        .out_cnt        (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [BUS_W-1:0] modelBus();
        logic [BUS_W-1:0] b;
        b = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            b[k*COEFF_W +: COEFF_W] = modelCoeff[k];
        end
        return b;
    endfunction

    // Caller sits on a negedge; the write lands on the following posedge.
    task automatic cfgWrite(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = ADDR_W'(addr);
        cfg_wdata = COEFF_W'(data);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic loadCoeffs(input int base);
        for (int k = 0; k < NUM_TAPS; k++) begin
            cfgWrite(k, base + k);
            modelCoeff[k] = coeff_t'(base + k);
        end
    endtask

    // One complete run. Cycle 0 is the first cycle after the start edge; the model
    // predicts slots, pushes, and the exact cycle at which done must appear.
    task automatic applyStimulus(input string tag, input int n, input int validPct,
                                 input int nOut, input int outPct, input bit seqData);
        logic [DATA_W-1:0] samples[$];
        logic [DATA_W-1:0] expPush[$];
        logic [DATA_W-1:0] actPush[$];
        int c, sent, given, lastAcc, tExp, doneCyc, doneCnt, lastPushCyc;
        int readyErr, busyErr, spaceErr, pushMis, expOut;
        int ls, condCyc, wdCyc, doneExp;
        bit slot, inRun, toExp;

        for (int i = 0; i < n; i++) begin
            samples.push_back(seqData ? DATA_W'(i + 1) : DATA_W'($urandom_range(0, 65535)));
        end
        expOut = (n + NUM_TAPS - 1) / DECIM;
        sent = 0; given = 0; lastAcc = -1; tExp = -1; doneCyc = -1; doneCnt = 0;
        lastPushCyc = -100; readyErr = 0; busyErr = 0; spaceErr = 0; pushMis = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < RUN_LIMIT) begin
            if (filt_valid) begin
                actPush.push_back(filt_sample);
                if (c - lastPushCyc < FILT_DIV) spaceErr++;
                lastPushCyc = c;
            end
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (doneCyc < 0 && !busy) busyErr++;

            slot  = ((c % FILT_DIV) == FILT_DIV - 1);
            inRun = (lastAcc < 0);
            if (inRun && (s_ready !== slot)) readyErr++;
            if (!inRun && (s_ready !== 1'b0)) readyErr++;

            if (inRun) begin
                s_valid = ($urandom_range(0, 99) < validPct);
                s_data  = samples[sent];
                s_last  = (sent == n - 1);
                if (s_valid && slot) begin
                    expPush.push_back(samples[sent]);
                    sent++;
                    if (sent == n) begin
                        lastAcc = c;
                        for (int z = 0; z < NUM_TAPS - 1; z++) expPush.push_back('0);
                    end
                end
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end

            filt_out_valid = (given < nOut) && (doneCyc < 0) &&
                             ($urandom_range(0, 99) < outPct);
            if (filt_out_valid) begin
                given++;
                if (given == expOut) tExp = c;
            end

            @(negedge clk);
            c++;
            if (doneCyc >= 0 && c > doneCyc + 3) break;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        filt_out_valid = 1'b0;

        checkOutput({tag, "_stream_ended"}, (lastAcc >= 0), 1'b1);
        checkOutput({tag, "_done_seen"}, (doneCyc >= 0), 1'b1);
        if (lastAcc >= 0) begin
            ls = lastAcc + FILT_DIV * (NUM_TAPS - 1);
            wdCyc = ls + TIMEOUT;
            condCyc = (tExp >= 0) ? ((tExp + 1 > ls + 1) ? tExp + 1 : ls + 1) : 1 << 30;
            toExp = (condCyc > wdCyc);
            doneExp = (toExp ? wdCyc : condCyc) + 1;
            checkOutput({tag, "_done_cycle"}, doneCyc, doneExp);
            checkOutput({tag, "_timeout"}, timeout, toExp);
        end
        checkOutput({tag, "_done_pulses"}, doneCnt, 1);
        checkOutput({tag, "_in_cnt"}, in_cnt, n);
        checkOutput({tag, "_out_cnt"}, out_cnt, given);
        checkOutput({tag, "_push_count"}, actPush.size(), expPush.size());
        for (int i = 0; i < expPush.size() && i < actPush.size(); i++) begin
            if (actPush[i] !== expPush[i]) pushMis++;
        end
        checkOutput({tag, "_push_data"}, pushMis, 0);
        checkOutput({tag, "_push_spacing"}, spaceErr, 0);
        checkOutput({tag, "_s_ready"}, readyErr, 0);
        checkOutput({tag, "_busy_during"}, busyErr, 0);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
        checkOutput({tag, "_cfg_err"}, cfg_err, 1'b0);
    endtask

    // Illegal write and ignored start during RUN, then reset while flushing.
    task automatic midRunTest();
        int c, acc, doneSeen;
        start   = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (c = 0; c < 8; c++) begin
            if ((c % FILT_DIV) == FILT_DIV - 1) acc++;
            s_data    = DATA_W'(16'h0100 + c);
            cfg_we    = (c == 3);
            cfg_addr  = '0;
            cfg_wdata = 16'hBEEF;
            start     = (c == 4);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        checkOutput("run_cfg_err", cfg_err, 1'b1);
        checkOutput("run_cfg_dropped", filt_coeff, modelBus());
        checkOutput("busy_start_in_cnt", in_cnt, acc);
        checkOutput("busy_start_busy", busy, 1'b1);

        s_last = 1'b1;
        while ((c % FILT_DIV) != FILT_DIV - 1) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("flush_busy", busy, 1'b1);
        checkOutput("flush_in_cnt", in_cnt, acc + 1);

        rst = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_coeff", filt_coeff, '0);
        checkOutput("rst_in_cnt", in_cnt, 0);
        checkOutput("rst_filt_valid", filt_valid, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("rst_no_done", doneSeen, 0);
        for (int k = 0; k < NUM_TAPS; k++) modelCoeff[k] = '0;
    endtask

    initial begin
        int nr, ne;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        filt_out_valid = 1'b0;
        for (int k = 0; k < NUM_TAPS; k++) modelCoeff[k] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_filt_valid", filt_valid, 1'b0);
        checkOutput("reset_filt_sample", filt_sample, '0);
        checkOutput("reset_coeff", filt_coeff, '0);
        checkOutput("reset_counts", {in_cnt, out_cnt}, '0);
        checkOutput("reset_flags", {timeout, cfg_err, s_ready}, '0);
        rst = 1'b0;
        @(negedge clk);

        loadCoeffs(1);
        checkOutput("coeff_load", filt_coeff, modelBus());
        checkOutput("coeff_load_err", cfg_err, 1'b0);
        cfgWrite(NUM_TAPS, 16'hDEAD);
        checkOutput("coeff_bad_addr_err", cfg_err, 1'b1);
        checkOutput("coeff_bad_addr_bank", filt_coeff, modelBus());

        applyStimulus("basic", 20, 100, (20 + NUM_TAPS - 1) / DECIM, 30, 1'b1);
        for (int r = 0; r < 3; r++) begin
            nr = $urandom_range(3, 24);
            ne = (nr + NUM_TAPS - 1) / DECIM;
            applyStimulus("bubble", nr, 50, ne, 40, 1'b0);
        end
        applyStimulus("wdog", 4, 100, 3, 50, 1'b0);
        applyStimulus("after_wdog", 6, 70, (6 + NUM_TAPS - 1) / DECIM, 50, 1'b0);

        midRunTest();
        loadCoeffs(16'h0200);
        checkOutput("reload_coeff", filt_coeff, modelBus());
        applyStimulus("post_reset", 10, 60, (10 + NUM_TAPS - 1) / DECIM, 40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/hbf_ctrl.md
Name: hbf_ctrl

Overview:
Sequencing controller for the half-band decimating filter (hbf_top). It owns the coefficient register bank, which is written through a simple config port. It gates input samples onto the filter at the filter rate using a clock-enable slot, which replaces the divided filter clock. At end of stream it flushes the delay line with zeros and reports completion once all expected decimated outputs have been seen.

Parameters:
DATA_W, 16, input sample width
COEFF_W, 16, coefficient width
NUM_TAPS, 11, filter taps (coefficient bank depth)
FILT_DIV, 2, clk cycles per filter slot (filter rate divider, >=1)
DECIM, 2, filter decimation ratio
CNT_W, 16, sample/output counter width
TIMEOUT, 256, WAIT_OUT watchdog in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  coefficient write strobe
cfg_addr  in  $clog2(NUM_TAPS)  coefficient index
cfg_wdata  in  COEFF_W  coefficient value
start  in  1  begin a run (pulse)
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts sample this cycle
s_data  in  DATA_W  input sample
s_last  in  1  final sample of stream (qualified by handshake)
filt_valid  out  1  sample strobe to filter
filt_sample  out  DATA_W  sample to filter
filt_coeff  out  NUM_TAPS*COEFF_W  flat coefficient bank, tap 0 in LSBs
filt_out_valid  in  1  filter output strobe
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
timeout  out  1  sticky: last run ended by watchdog; cleared on start
cfg_err  out  1  sticky: illegal cfg write; cleared on accepted start
in_cnt  out  CNT_W  samples accepted in current/last run
out_cnt  out  CNT_W  filter outputs seen in current/last run

Behaviour:
- Reset: state IDLE; coefficient bank, all counters, filt_sample and all flags/strobes = 0.
- FSM states: IDLE, RUN, FLUSH, WAIT_OUT.
- Coefficient writes:
  - Applied only in IDLE with cfg_addr < NUM_TAPS; take effect on filt_coeff the next cycle.
  - A write in any other state, or with cfg_addr >= NUM_TAPS, is dropped and sets cfg_err.
- Start:
  - start in IDLE -> RUN next cycle; clears in_cnt, out_cnt, timeout and cfg_err; div_cnt = 0.
  - start outside IDLE is ignored.
  - A cfg_we in the same cycle as an accepted start is applied; start wins the transition.
- Slot timing:
  - div_cnt counts 0..FILT_DIV-1 and wraps, running in RUN and FLUSH.
  - slot = (div_cnt == FILT_DIV-1). With FILT_DIV=1, every cycle is a slot.
- RUN:
  - s_ready = slot (combinational from state/div_cnt).
  - On s_valid && s_ready: next cycle filt_valid = 1, filt_sample = s_data, in_cnt += 1 (saturating at all-ones).
  - Slot without s_valid: bubble, filt_valid = 0.
  - Accepted beat with s_last -> FLUSH, flush_cnt = 0.
- FLUSH:
  - s_ready = 0.
  - Each slot issues filt_valid = 1 with filt_sample = 0, NUM_TAPS-1 times; after the last one -> WAIT_OUT.
- filt_valid is high exactly one cycle per push. filt_sample holds its value between pushes.
- Output counting: out_cnt += 1 on filt_out_valid in any non-IDLE state (saturating); ignored in IDLE.
- WAIT_OUT:
  - exp = (in_cnt + NUM_TAPS - 1) / DECIM (floor).
  - When out_cnt >= exp -> IDLE with done = 1 for one cycle. This also covers the case where exp is already reached on entry.
  - Watchdog counts cycles in WAIT_OUT. At TIMEOUT cycles -> IDLE, done = 1, timeout = 1.
- Outputs arriving in RUN/FLUSH still count toward exp.
- Reset mid-run: immediate return to IDLE, coefficient bank cleared, no done pulse.

Decomposition:
- Package hbf_pkg holds:
  - DATA_W/COEFF_W/NUM_TAPS defaults
  - state enum type hbf_ctrl_state_t {IDLE, RUN, FLUSH, WAIT_OUT}
  - coeff_t typedef
- Sub-module hbf_coeff_bank: register array, write port with address check and err output, flat read bus.
- FSM, slot divider and counters stay in hbf_ctrl.

Test Plan:
- Coeff load: write 1..11 to addr 0..10 in IDLE -> filt_coeff tap k = k+1. Write addr 11 -> cfg_err = 1, bank unchanged. Write during RUN -> dropped, cfg_err = 1.
- Basic run, FILT_DIV=2, s_valid held high, 20 samples 0x0001..0x0014 with s_last on 20th:
  - s_ready high every 2nd cycle.
  - 20 filt_valid pushes carry data in order, then 10 zero pushes.
  - in_cnt = 20; exp = 15.
  - After 15 filt_out_valid pulses: done pulses once, busy falls.
- Bubbles: s_valid toggled randomly -> only handshaked beats pushed, never two filt_valid closer than 2 cycles, in_cnt matches handshake count.
- Watchdog: run 4 samples, supply only 3 outputs (exp = 7) -> done and timeout = 1 after 256 WAIT_OUT cycles. Next start clears timeout.
- Reset mid-FLUSH: assert rst -> next edge busy = 0, filt_coeff all 0, no done. New start after re-load runs normally.
- start while busy: pulse start in RUN -> ignored, counters not cleared.
